// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store controller with req/gnt/rvalid bus, pipeline stall and timeout abort
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        i_clk,
  input  logic        i_rst_mem,
  input  logic        inst_vld_mem,
  input  logic        mem_wren_mem,
  input  logic [3:0]  lsu_op_mem,
  input  logic [31:0] alu_data_mem,
  input  logic [31:0] rs2_data_mem,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_stall,
  output logic [31:0] o_ld_data,
  output logic        o_ld_vld,
  output logic        o_misaligned,
  output logic        o_bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;
  logic [2:0]       w_f3;
  logic [1:0]       w_off;
  logic             w_f3_ok, w_acc, w_half, w_word, w_mis, w_to;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_sh, w_ld;
  assign w_f3    = lsu_op_mem[2:0];
  assign w_off   = alu_data_mem[1:0];
  assign w_f3_ok = (w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd2 || (!mem_wren_mem && (w_f3 == 3'd4 || w_f3 == 3'd5)));
  assign w_acc   = inst_vld_mem & lsu_op_mem[3] & w_f3_ok;
  assign w_half  = w_f3[1:0] == 2'd1;
  assign w_word  = w_f3[1:0] == 2'd2;
  assign w_mis   = (w_half & w_off[0]) | (w_word & |w_off);
  assign w_be    = w_word ? 4'hf : w_half ? 4'b0011 << w_off : 4'b0001 << w_off;
  assign w_wdata = w_word ? rs2_data_mem : w_half ? {2{rs2_data_mem[15:0]}} : {4{rs2_data_mem[7:0]}};
  assign w_sh    = i_bus_rdata >> {r_off, 3'b000};
  assign w_ld    = r_f3[1] ? i_bus_rdata :
                   r_f3[0] ? {{16{~r_f3[2] & w_sh[15]}}, w_sh[15:0]} :
                             {{24{~r_f3[2] & w_sh[7]}}, w_sh[7:0]};
  assign w_to    = r_cnt == CNT_W'(TIMEOUT - 1);
  assign o_stall = i_rst_mem & ((r_state == IDLE & w_acc) | r_state == REQ | r_state == RESP);
  always_ff @(posedge i_clk) begin
    if (!i_rst_mem) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_f3         <= '0;
      r_off        <= '0;
      o_bus_req    <= 1'b0;
      o_bus_we     <= 1'b0;
      o_bus_addr   <= '0;
      o_bus_be     <= '0;
      o_bus_wdata  <= '0;
      o_ld_data    <= '0;
      o_ld_vld     <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      o_ld_vld     <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
      case (r_state)
        IDLE: if (w_acc && w_mis) begin
          r_state      <= DONE;
          o_misaligned <= 1'b1;
        end else if (w_acc) begin
          r_state     <= REQ;
          r_cnt       <= '0;
          r_f3        <= w_f3;
          r_off       <= w_off;
          o_bus_req   <= 1'b1;
          o_bus_we    <= mem_wren_mem;
          o_bus_addr  <= {alu_data_mem[31:2], 2'b00};
          o_bus_be    <= w_be;
          o_bus_wdata <= w_wdata;
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
            r_state   <= o_bus_we ? DONE : RESP;
          end else if (w_to) begin
            o_bus_req <= 1'b0;
            o_bus_err <= 1'b1;
            o_ld_data <= '0;
            r_state   <= DONE;
          end
        end
        RESP: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_bus_rvalid) begin
            o_ld_data <= w_ld;
            o_ld_vld  <= 1'b1;
            r_state   <= DONE;
          end else if (w_to) begin
            o_bus_err <= 1'b1;
            o_ld_data <= '0;
            r_state   <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst_mem, inst_vld_mem, mem_wren_mem;
  logic [3:0]  lsu_op_mem;
  logic [31:0] alu_data_mem, rs2_data_mem;
  logic        o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt, i_bus_rvalid;
  logic [31:0] i_bus_rdata;
  logic        o_stall, o_ld_vld, o_misaligned, o_bus_err;
  logic [31:0] o_ld_data;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_stall, n_req;
  logic [3:0]  a_be;
  logic [31:0] a_wd, a_ba, a_data;
  logic        a_vld, a_mis, a_err, a_ok;
  always #5 i_clk = ~i_clk;
  lsu_mem_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
    .i_clk(i_clk), .i_rst_mem(i_rst_mem), .inst_vld_mem(inst_vld_mem),
    .mem_wren_mem(mem_wren_mem), .lsu_op_mem(lsu_op_mem), .alu_data_mem(alu_data_mem),
    .rs2_data_mem(rs2_data_mem), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
    .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
    .o_stall(o_stall), .o_ld_data(o_ld_data), .o_ld_vld(o_ld_vld),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] rdata, input int gdly);
    logic prev_gnt;
    prev_gnt = 1'b0;
    a_ok = 1'b0;
    n_stall = 0;
    n_req = 0;
    a_be = '0; a_wd = '0; a_ba = '0;
    inst_vld_mem = 1'b1; mem_wren_mem = we; lsu_op_mem = {1'b1, f3};
    alu_data_mem = addr; rs2_data_mem = rs2; i_bus_rdata = rdata;
    #1;
    for (int c = 0; c < 40 && !a_ok; c++) begin
      if (c > 0 && !o_stall) begin
        a_ok = 1'b1;
        a_vld = o_ld_vld; a_data = o_ld_data; a_mis = o_misaligned; a_err = o_bus_err;
      end else begin
        if (o_stall) n_stall++;
        if (o_bus_req) begin
          n_req++;
          a_be = o_bus_be; a_wd = o_bus_wdata; a_ba = o_bus_addr;
        end
        i_bus_gnt = o_bus_req && (n_req > gdly);
        i_bus_rvalid = prev_gnt & ~we;
        prev_gnt = i_bus_gnt;
        tick();
      end
    end
    check("access_done", {31'b0, a_ok}, 32'd1);
    inst_vld_mem = 1'b0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
    tick();
  endtask
  initial begin
    i_rst_mem = 1'b0; inst_vld_mem = 1'b1; mem_wren_mem = 1'b0; lsu_op_mem = 4'b1010;
    alu_data_mem = 32'h100; rs2_data_mem = '0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
    i_bus_rdata = '0;
    tick(); tick();
    check("rst_req", {31'b0, o_bus_req}, 32'd0);
    check("rst_stall", {31'b0, o_stall}, 32'd0);
    check("rst_ld_data", o_ld_data, 32'h0);
    check("rst_addr", o_bus_addr, 32'h0);
    inst_vld_mem = 1'b0;
    i_rst_mem = 1'b1;
    tick();
    access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_stall", n_stall, 3);
    check("lw_req", n_req, 1);
    check("lw_addr", a_ba, 32'h100);
    check("lw_be", {28'b0, a_be}, 32'hf);
    check("lw_vld", {31'b0, a_vld}, 32'd1);
    check("lw_data", a_data, 32'hDEADBEEF);
    check("lw_vld_pulse", {31'b0, o_ld_vld}, 32'd0);
    check("lw_data_hold", o_ld_data, 32'hDEADBEEF);
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0);
    check("lb_be", {28'b0, a_be}, 32'h8);
    check("lb_data", a_data, 32'hFFFFFF80);
    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 0);
    check("lbu_data", a_data, 32'h00000080);
    access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF0000, 1);
    check("lh_be", {28'b0, a_be}, 32'hC);
    check("lh_data", a_data, 32'hFFFF80FF);
    check("lh_stall", n_stall, 4);
    access(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF0000, 0);
    check("lhu_data", a_data, 32'h000080FF);
    access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 4);
    check("sh_req", n_req, 5);
    check("sh_stall", n_stall, 6);
    check("sh_be", {28'b0, a_be}, 32'hC);
    check("sh_wdata", a_wd, 32'hABCDABCD);
    check("sh_addr", a_ba, 32'h200);
    check("sh_no_vld", {31'b0, a_vld}, 32'd0);
    check("sh_ld_hold", o_ld_data, 32'h000080FF);
    access(1'b1, 3'd0, 32'h201, 32'h000000CD, 32'h0, 0);
    check("sb_be", {28'b0, a_be}, 32'h2);
    check("sb_wdata", a_wd, 32'hCDCDCDCD);
    check("sb_stall", n_stall, 2);
    access(1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0, 0);
    check("sw_be", {28'b0, a_be}, 32'hF);
    check("sw_wdata", a_wd, 32'hCAFEF00D);
    access(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
    check("mis_req", n_req, 0);
    check("mis_stall", n_stall, 1);
    check("mis_pulse", {31'b0, a_mis}, 32'd1);
    check("mis_pulse_end", {31'b0, o_misaligned}, 32'd0);
    access(1'b0, 3'd1, 32'h105, 32'h0, 32'h0, 0);
    check("mis_lh", {31'b0, a_mis}, 32'd1);
    inst_vld_mem = 1'b1; mem_wren_mem = 1'b0; lsu_op_mem = 4'b0010;
    i_bus_gnt = 1'b1; i_bus_rvalid = 1'b1;
    #1;
    check("noacc_stall", {31'b0, o_stall}, 32'd0);
    tick();
    check("noacc_req", {31'b0, o_bus_req}, 32'd0);
    check("spur_vld", {31'b0, o_ld_vld}, 32'd0);
    inst_vld_mem = 1'b0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0;
    access(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 100);
    check("to_req", n_req, 8);
    check("to_stall", n_stall, 9);
    check("to_err", {31'b0, a_err}, 32'd1);
    check("to_no_vld", {31'b0, a_vld}, 32'd0);
    check("to_data", a_data, 32'h0);
    access(1'b0, 3'd2, 32'h500, 32'h0, 32'h12345678, 0);
    check("pre_rst_data", a_data, 32'h12345678);
    inst_vld_mem = 1'b1; mem_wren_mem = 1'b0; lsu_op_mem = 4'b1010; alu_data_mem = 32'h600;
    tick();
    i_bus_gnt = 1'b1;
    tick();
    i_bus_gnt = 1'b0;
    check("rr_in_resp", {31'b0, o_stall}, 32'd1);
    i_rst_mem = 1'b0;
    tick();
    check("rr_req", {31'b0, o_bus_req}, 32'd0);
    check("rr_stall", {31'b0, o_stall}, 32'd0);
    check("rr_data", o_ld_data, 32'h0);
    check("rr_addr", o_bus_addr, 32'h0);
    i_rst_mem = 1'b1; inst_vld_mem = 1'b0;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFFFFFF;
    tick();
    i_bus_rvalid = 1'b0;
    check("rr_late_vld", {31'b0, o_ld_vld}, 32'd0);
    check("rr_late_data", o_ld_data, 32'h0);
    check("rr_idle_stall", {31'b0, o_stall}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
